md_issue_ctrl: RTL and testbench

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

---
 rtl/md_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_md_issue_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue controller: classifies HI/LO-unit instructions in D, stalls as
// needed, launches commands to the mult/div responder, supervises its busy handshake.
module md_issue_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_vld,
  input  logic [5:0]  instr_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        Req,
  output logic        stall,
  output logic        start,
  output logic [5:0]  mdu_op,
  output logic [31:0] mdu_num1,
  output logic [31:0] mdu_num2,
  input  logic        busy,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic        rd_vld,
  output logic [31:0] rd_data,
  output logic        proto_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_READ} state_t;

  state_t        r_state, w_next;
  logic [5:0]    r_op;
  logic [31:0]   r_num1, r_num2;
  logic [CW-1:0] r_cnt;

  logic w_md, w_mt, w_mf, w_cls, w_accept, w_r_md;
  logic w_wait_first, w_wait_max;

  assign w_md     = (instr_op >= 6'h18) && (instr_op <= 6'h1B);
  assign w_mt     = (instr_op == 6'h11) || (instr_op == 6'h13);
  assign w_mf     = (instr_op == 6'h10) || (instr_op == 6'h12);
  assign w_cls    = w_md || w_mt || w_mf;
  assign w_accept = instr_vld && w_cls && (r_state == S_IDLE) && !busy && !Req;
  assign stall    = instr_vld && w_cls && !w_accept;

  assign w_r_md       = (r_op >= 6'h18) && (r_op <= 6'h1B);
  assign w_wait_first = (r_cnt == CW'(1));
  assign w_wait_max   = (r_cnt == CW'(MAX_WAIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_mf ? S_READ : S_ISSUE;
      end
      S_ISSUE: begin
        w_next = (w_r_md && !Req) ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        // Req is deliberately ignored here: once launched the operation is committed
        if (!busy || w_wait_max) w_next = S_IDLE;
      end
      S_READ: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    mdu_op   = '0;
    mdu_num1 = '0;
    mdu_num2 = '0;
    if (r_state == S_ISSUE) begin
      mdu_num1 = r_num1;
      mdu_num2 = r_num2;
      if (!Req) begin
        mdu_op = r_op;
        start  = w_r_md;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op   <= '0;
      r_num1 <= '0;
      r_num2 <= '0;
    end else if (w_accept) begin
      r_op   <= instr_op;
      r_num1 <= rs_val;
      r_num2 <= rt_val;
    end
  end

  // Counter reads 1 in the first WAIT cycle so it directly equals WAIT cycles elapsed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE && w_next == S_WAIT) begin
      r_cnt <= CW'(1);
    end else if (r_state == S_WAIT && w_next == S_WAIT) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if ((!busy && w_wait_first) || (busy && w_wait_max)) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld <= (r_state == S_READ);
      if (r_state == S_READ) rd_data <= (r_op == 6'h10) ? hi : lo;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: issue/read scoreboards plus directed handshake,
// cancellation, timeout and reset scenarios.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_vld;
  logic [5:0]  instr_op;
  logic [31:0] rs_val, rt_val;
  logic        Req;
  logic        stall, start;
  logic [5:0]  mdu_op;
  logic [31:0] mdu_num1, mdu_num2;
  logic        busy;
  logic [31:0] hi, lo;
  logic        rd_vld;
  logic [31:0] rd_data;
  logic        proto_err;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;

  iss_t        q_iss[$];
  logic [31:0] q_rd[$];
  iss_t        e_iss;
  logic [31:0] e_rd;

  int n_total = 0;
  int n_bad   = 0;

  md_issue_ctrl #(.MAX_WAIT(16)) dut (
    .clk(clk), .reset(reset), .instr_vld(instr_vld), .instr_op(instr_op),
    .rs_val(rs_val), .rt_val(rt_val), .Req(Req), .stall(stall), .start(start),
    .mdu_op(mdu_op), .mdu_num1(mdu_num1), .mdu_num2(mdu_num2), .busy(busy),
    .hi(hi), .lo(lo), .rd_vld(rd_vld), .rd_data(rd_data), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every start pulse and every rd_vld pulse must match a queued expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (start) begin
        if (q_iss.size() == 0) chk("unexp_start", 32'd1, 32'd0);
        else begin
          e_iss = q_iss.pop_front();
          chk("iss_op", {26'd0, mdu_op}, {26'd0, e_iss.op});
          chk("iss_num1", mdu_num1, e_iss.a);
          chk("iss_num2", mdu_num2, e_iss.b);
        end
      end
      if (rd_vld) begin
        if (q_rd.size() == 0) chk("unexp_rdvld", 32'd1, 32'd0);
        else begin
          e_rd = q_rd.pop_front();
          chk("rd_data", rd_data, e_rd);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; instr_vld = 1'b0; instr_op = '0; rs_val = '0; rt_val = '0;
    Req = 1'b0; busy = 1'b0; hi = '0; lo = '0;
    @(negedge clk);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_op", {26'd0, mdu_op}, 32'd0);
    chk("rst_rdvld", {31'd0, rd_vld}, 32'd0);
    chk("rst_rddata", rd_data, 32'd0);
    chk("rst_perr", {31'd0, proto_err}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // mult with 5 busy cycles, then mfhi in the first IDLE cycle
    instr_vld = 1'b1; instr_op = 6'h18; rs_val = 32'h7; rt_val = 32'hFFFFFFFE;
    q_iss.push_back({6'h18, 32'h7, 32'hFFFFFFFE});
    @(negedge clk); chk("t1_stall", {31'd0, stall}, 32'd0);
    step(); instr_vld = 1'b0;
    @(negedge clk); chk("t1_start", {31'd0, start}, 32'd1);
    step(); busy = 1'b1;
    repeat (5) step();
    busy = 1'b0;
    step();
    instr_vld = 1'b1; instr_op = 6'h10; hi = 32'hCAFE0001;
    q_rd.push_back(32'hCAFE0001);
    @(negedge clk); chk("t1_idle_accept", {31'd0, stall}, 32'd0);
    step(); instr_vld = 1'b0;
    step();
    @(negedge clk);
    chk("t1_rdvld", {31'd0, rd_vld}, 32'd1);
    chk("t1_perr", {31'd0, proto_err}, 32'd0);

    // mflo presented while an MD op is busy
    step();
    instr_vld = 1'b1; instr_op = 6'h18; rs_val = 32'h3; rt_val = 32'h5;
    q_iss.push_back({6'h18, 32'h3, 32'h5});
    step(); instr_op = 6'h12;
    @(negedge clk); chk("t2_stall_iss", {31'd0, stall}, 32'd1);
    step(); busy = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk); chk("t2_stall_wait", {31'd0, stall}, 32'd1);
      step();
    end
    busy = 1'b0; lo = 32'h1234;
    q_rd.push_back(32'h00001234);
    @(negedge clk); chk("t2_stall_last", {31'd0, stall}, 32'd1);
    step();
    @(negedge clk); chk("t2_stall_idle", {31'd0, stall}, 32'd0);
    step(); instr_vld = 1'b0;
    step();
    @(negedge clk); chk("t2_rdvld", {31'd0, rd_vld}, 32'd1);
    step();
    @(negedge clk);
    chk("t2_rdvld_drop", {31'd0, rd_vld}, 32'd0);
    chk("t2_rd_hold", rd_data, 32'h00001234);

    // div cancelled by Req in ISSUE, then mthi right after
    step();
    instr_vld = 1'b1; instr_op = 6'h1A; rs_val = 32'h64; rt_val = 32'h9;
    step(); instr_vld = 1'b0; Req = 1'b1;
    @(negedge clk);
    chk("t3_start", {31'd0, start}, 32'd0);
    chk("t3_op", {26'd0, mdu_op}, 32'd0);
    step(); Req = 1'b0;
    instr_vld = 1'b1; instr_op = 6'h11; rs_val = 32'hDEADBEEF; rt_val = 32'h0;
    @(negedge clk); chk("t3_idle_accept", {31'd0, stall}, 32'd0);
    step(); instr_vld = 1'b0;
    @(negedge clk);
    chk("t4_mthi_op", {26'd0, mdu_op}, 32'h11);
    chk("t4_mthi_num1", mdu_num1, 32'hDEADBEEF);
    chk("t4_mthi_start", {31'd0, start}, 32'd0);
    step();

    // instr_vld with Req in IDLE, and an unclassified op
    instr_vld = 1'b1; instr_op = 6'h18; Req = 1'b1;
    @(negedge clk); chk("t5_req_stall", {31'd0, stall}, 32'd1);
    step();
    @(negedge clk); chk("t5_req_noissue", {26'd0, mdu_op}, 32'd0);
    step(); Req = 1'b0; instr_op = 6'h20;
    @(negedge clk); chk("t5_other_stall", {31'd0, stall}, 32'd0);
    step(); instr_vld = 1'b0;
    @(negedge clk); chk("t5_other_noissue", {26'd0, mdu_op}, 32'd0);
    step();

    // multu timeout with Req pulsed mid-WAIT
    instr_vld = 1'b1; instr_op = 6'h19; rs_val = 32'h11; rt_val = 32'h22;
    q_iss.push_back({6'h19, 32'h11, 32'h22});
    step(); instr_vld = 1'b0;
    step(); busy = 1'b1;
    for (int unsigned i = 1; i <= 16; i++) begin
      @(negedge clk); chk("t6_perr_low", {31'd0, proto_err}, 32'd0);
      if (i == 4) Req = 1'b1;
      if (i == 8) Req = 1'b0;
      step();
    end
    @(negedge clk); chk("t6_perr_set", {31'd0, proto_err}, 32'd1);
    busy = 1'b0;
    repeat (3) step();
    @(negedge clk); chk("t6_perr_sticky", {31'd0, proto_err}, 32'd1);
    step();

    // asynchronous reset mid-WAIT
    instr_vld = 1'b1; instr_op = 6'h18; rs_val = 32'h1; rt_val = 32'h2;
    q_iss.push_back({6'h18, 32'h1, 32'h2});
    step(); instr_vld = 1'b0;
    step(); busy = 1'b1;
    step(); step();
    #2 reset = 1'b1;
    #1;
    chk("t7_start", {31'd0, start}, 32'd0);
    chk("t7_op", {26'd0, mdu_op}, 32'd0);
    chk("t7_num1", mdu_num1, 32'd0);
    chk("t7_num2", mdu_num2, 32'd0);
    chk("t7_rdvld", {31'd0, rd_vld}, 32'd0);
    chk("t7_rddata", rd_data, 32'd0);
    chk("t7_perr", {31'd0, proto_err}, 32'd0);
    busy = 1'b0;
    step(); reset = 1'b0;
    repeat (3) step();

    // reset during ISSUE: no start may follow
    instr_vld = 1'b1; instr_op = 6'h1B; rs_val = 32'h5; rt_val = 32'h6;
    step(); instr_vld = 1'b0;
    #1 reset = 1'b1;
    #1 chk("t8_start", {31'd0, start}, 32'd0);
    step(); reset = 1'b0;
    repeat (3) step();

    // responder never raises busy
    instr_vld = 1'b1; instr_op = 6'h19; rs_val = 32'hA; rt_val = 32'hB;
    q_iss.push_back({6'h19, 32'hA, 32'hB});
    step(); instr_vld = 1'b0;
    step();
    @(negedge clk); chk("t9_perr_first", {31'd0, proto_err}, 32'd0);
    step();
    @(negedge clk); chk("t9_perr_set", {31'd0, proto_err}, 32'd1);
    step();

    chk("q_iss_empty", q_iss.size(), 32'd0);
    chk("q_rd_empty", q_rd.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
